// File: rtl/fifo.sv
// Three-row line-buffer chain: each accepted pixel yields the column triple (r-2, r-1, r).
// Optional build macro FIFO_PIXCNT_EN adds the pix_cnt accepted-pixel count output.
module fifo #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] fifo1_data_o,
  output logic [DATA_W-1:0] fifo2_data_o,
  output logic [DATA_W-1:0] fifo3_data_o,
  output logic              idle,
  output logic              ready,
  output logic              done
`ifdef FIFO_PIXCNT_EN
  ,
  output logic [CNT_W-1:0]  pix_cnt
`endif
);

  localparam int PTR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(IMG_W * IMG_H);
  localparam logic [CNT_W-1:0] ROW1_FILL = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] ROW2_FILL = CNT_W'(2 * IMG_W);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(IMG_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROC,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [PTR_W-1:0]  ptr;
  logic [DATA_W-1:0] mem3 [IMG_W];
  logic [DATA_W-1:0] mem2 [IMG_W];
  logic              fifo3_full;
  logic              fifo2_full;
  logic              accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= PIX_TOTAL) ? PIX_TOTAL : v + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Row FIFOs advance together, so one pointer serves both; fill level follows from cnt.
  assign fifo3_full = (cnt >= ROW1_FILL);
  assign fifo2_full = (cnt >= ROW2_FILL);
  assign accept     = (state == S_IDLE) && data_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idle         <= 1'b1;
      ready        <= 1'b0;
      done         <= 1'b0;
      cnt          <= '0;
      ptr          <= '0;
      fifo1_data_o <= '0;
      fifo2_data_o <= '0;
      fifo3_data_o <= '0;
      for (int i = 0; i < IMG_W; i++) begin
        mem3[i] <= '0;
        mem2[i] <= '0;
      end
    end else begin
      ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            // FIFO1's popped head is never used, so only its input value is kept.
            mem3[ptr]    <= data_i;
            mem2[ptr]    <= fifo3_full ? mem3[ptr] : '0;
            fifo3_data_o <= data_i;
            fifo2_data_o <= fifo3_full ? mem3[ptr] : '0;
            fifo1_data_o <= fifo2_full ? mem2[ptr] : '0;
            ptr          <= ptr_next(ptr);
            cnt          <= sat_inc(cnt);
            ready        <= fifo2_full;
            done         <= (sat_inc(cnt) == PIX_TOTAL);
            idle         <= 1'b0;
            state        <= S_PROC;
          end
        end
        S_PROC: begin
          if (cnt == PIX_TOTAL) begin
            state <= S_DONE;
          end else begin
            state <= S_IDLE;
            idle  <= 1'b1;
          end
        end
        S_DONE: begin
          idle <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          idle  <= 1'b1;
        end
      endcase
    end
  end

`ifdef FIFO_PIXCNT_EN
  assign pix_cnt = cnt;
`endif

endmodule

// File: tb/tb_fifo.sv
// Randomized bench for fifo, checked every cycle against a pixel-history reference model.
module tb_fifo;
  localparam int W = 5;
  localparam int H = 5;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic [7:0] fifo1_data_o, fifo2_data_o, fifo3_data_o;
  logic       idle, ready, done;
`ifdef FIFO_PIXCNT_EN
  logic [7:0] pix_cnt;
`endif

  fifo #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_valid(data_valid),
    .data_i(data_i),
    .fifo1_data_o(fifo1_data_o),
    .fifo2_data_o(fifo2_data_o),
    .fifo3_data_o(fifo3_data_o),
    .idle(idle),
    .ready(ready),
    .done(done)
`ifdef FIFO_PIXCNT_EN
    ,
    .pix_cnt(pix_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the list of accepted pixels plus the handshake phase.
  int px[$];
  int m_n;
  bit m_busy, m_done, m_ready;
  int m_f1, m_f2, m_f3;
  int ready_cnt, idle_hi, accepts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int k);
    return (k >= 1) ? px[k-1] : 0;
  endfunction

  task automatic model_reset();
    px.delete();
    m_n = 0; m_busy = 0; m_done = 0; m_ready = 0;
    m_f1 = 0; m_f2 = 0; m_f3 = 0;
  endtask

  task automatic clear_stats();
    ready_cnt = 0; idle_hi = 0; accepts = 0;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    bit acc;
    data_valid = v;
    data_i = d;
    acc = rst_n && v && !m_busy && !m_done;
    if (idle === 1'b1) idle_hi++;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_ready = 0;
      m_busy = 0;
      if (acc) begin
        px.push_back(int'(d));
        m_n++;
        accepts++;
        m_busy = 1;
        m_f3 = int'(d);
        m_f2 = pix(m_n - W);
        m_f1 = pix(m_n - 2 * W);
        m_ready = (m_n >= 2 * W + 1);
        if (m_n == N) m_done = 1;
      end
    end
    #1;
    chk("idle", idle, !m_busy && !m_done);
    chk("ready", ready, m_ready);
    chk("done", done, m_done);
    chk("fifo1", fifo1_data_o, m_f1);
    chk("fifo2", fifo2_data_o, m_f2);
    chk("fifo3", fifo3_data_o, m_f3);
`ifdef FIFO_PIXCNT_EN
    chk("pix_cnt", pix_cnt, m_n);
`endif
    if (ready === 1'b1) ready_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    rst_n = 1'b1;
    clear_stats();
  endtask

  initial begin
    int g;
    model_reset();
    clear_stats();

    // Reset state
    do_reset();
    chk("rst_idle", idle, 1);

    // Continuous valid, ramp 0x01..0x19: acceptance every second cycle
    g = 0;
    while (m_n < N && g < 200) begin
      cycle(1'b1, 8'(m_n + 1));
      g++;
    end
    chk("frameA_len", m_n, N);
    chk("frameA_pulses", ready_cnt, 15);
    chk("idle_vs_accepts", idle_hi, accepts);
    chk("last_f1", fifo1_data_o, 8'h0F);
    chk("last_f2", fifo2_data_o, 8'h14);
    chk("last_f3", fifo3_data_o, 8'h19);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h00);
    chk("post_done_f3", fifo3_data_o, 8'h19);

    // Random data with gaps, reset after 13 pixels
    do_reset();
    g = 0;
    while (m_n < 13 && g < 300) begin
      if (m_n == 7 && !m_busy) begin
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'($urandom));
      end
      cycle(1'($urandom_range(0, 1)), 8'($urandom));
      g++;
    end
    chk("midframe_len", m_n, 13);
    do_reset();
    chk("midreset_f3", fifo3_data_o, 0);
    g = 0;
    while (m_n < 11 && g < 100) begin
      cycle(1'b1, 8'(m_n + 1));
      g++;
    end
    chk("first_ready", ready, 1);
    chk("first_pulses", ready_cnt, 1);
    chk("first_f1", fifo1_data_o, 8'h01);
    chk("first_f2", fifo2_data_o, 8'h06);
    chk("first_f3", fifo3_data_o, 8'h0B);
    chk("first_idle", idle, 0);

    // Fully random frame
    do_reset();
    g = 0;
    while (!m_done && g < 2000) begin
      cycle(1'($urandom_range(0, 2) != 0), 8'($urandom));
      g++;
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom));
    chk("frameC_len", m_n, N);
    chk("frameC_pulses", ready_cnt, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Three-row line-buffer FIFO chain for a streaming 8-bit image of IMG_W x IMG_H pixels (default 5x5 = 25 pixels).
- Pixels enter in raster order. Each accepted pixel produces a vertically aligned column triple: rows r-2, r-1 and r, same column.
- This triple feeds the downstream 3-row window and convolution stages of the stitching pipeline.
- Handshake is via idle/data_valid. ready flags a valid triple; done flags that the whole frame has been consumed.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 5, pixels per row; this is also the depth of each row FIFO.
- IMG_H, 5, rows per frame.
- CNT_W, 8, width of the internal pixel counter; must satisfy 2^CNT_W > IMG_W*IMG_H.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- data_valid, input, 1, data_i carries a pixel this cycle.
- data_i, input, DATA_W, input pixel.
- fifo1_data_o, output, DATA_W, oldest row (r-2) pixel.
- fifo2_data_o, output, DATA_W, middle row (r-1) pixel.
- fifo3_data_o, output, DATA_W, newest row (r) pixel.
- idle, output, 1, block can accept a pixel this cycle.
- ready, output, 1, one-cycle pulse: the fifo*_data_o triple is valid.
- done, output, 1, sticky: all IMG_W*IMG_H pixels have been accepted.

Behaviour:
Reset:
- rst_n=0 at a rising edge clears all FIFO storage, pointers, the counter, the outputs and ready/done to 0.
- State goes to IDLE, so idle=1 from the first cycle after reset.

State machine (IDLE, PROC, DONE):
- IDLE: idle=1. data_valid=1 accepts data_i (an accept) and goes to PROC. Otherwise stays in IDLE and holds everything.
- PROC: idle=0 for exactly one cycle. The shift is completed and the outputs are registered. Next state is DONE if the count equals IMG_W*IMG_H, else IDLE.
- DONE: idle=0, done=1. Further data_valid is ignored. Leaves DONE only on reset.
- data_valid while idle=0 is ignored; no pixel is lost or duplicated. Maximum throughput is one pixel per 2 cycles.

Data chain:
- Accepted pixel is pushed into FIFO3.
- When FIFO3 holds IMG_W entries, its popped head goes into FIFO2. When FIFO2 is full, its head goes into FIFO1. FIFO1's popped head is discarded.
- Net effect, for the n-th accepted pixel p[n] (n from 1), on the cycle after the accept:
  - fifo3_data_o = p[n]
  - fifo2_data_o = p[n-IMG_W]
  - fifo1_data_o = p[n-2*IMG_W]
  - Any term with an index below 1 reads 0.
- Outputs hold their value until the next accept.

ready:
- Pulses high for one cycle, the same cycle the outputs update, for every accept with n >= 2*IMG_W+1, i.e. all three rows are valid.
- Low otherwise. Defaults give 15 pulses, for n = 11..25.

done:
- Rises in the cycle after the accept of pixel IMG_W*IMG_H, together with that pixel's final ready pulse.

Counter and storage:
- Counter width is CNT_W; it saturates at IMG_W*IMG_H and never wraps.
- FIFO pointers wrap modulo IMG_W.
- Reset mid-frame discards all data and restarts at n=1.

Optional Feature:
- Macro FIFO_PIXCNT_EN. When defined, adds output port pix_cnt (CNT_W bits) equal to the number of accepted pixels: 0 after reset, updates in the same cycle as the outputs, saturates at IMG_W*IMG_H.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> all three outputs 0x00, ready=0, done=0; idle=1 after release.
- Feed 0x01..0x0B one per idle cycle -> no ready for the first 10. After the 11th accept: ready=1 for one cycle, fifo1=0x01, fifo2=0x06, fifo3=0x0B; idle=0 that cycle.
- Feed 0x01..0x19 (25 pixels) -> exactly 15 ready pulses. The final triple is 0x0F/0x14/0x19, done=1 and idle=0 thereafter. A 26th data_valid with data 0x00 changes nothing.
- Hold data_valid=1 continuously -> pixels accepted only in idle=1 cycles (every 2nd cycle); accept count matches the number of idle-high cycles.
- Gaps with data_valid=0 for 5 cycles mid-stream -> outputs, ready=0 and the count are held; the sequence resumes correctly.
- Assert rst_n=0 after 13 pixels -> everything clears. Re-feeding 0x01..0x0B again gives first ready with 0x01/0x06/0x0B.
